// File: rtl/wreg_track_unit.sv
// wreg_track_unit
//   Tracks pending register-file writes through the EX, MEM and WB slots and
//   compares them against the ID-stage source registers. Produces the
//   load-use stall, the registered EX forwarding selects, and the WB->ID
//   bypass flags.
//
// Ports:
//   clk, rst_n            core clock (rising edge), async active-low reset
//   id_valid              ID holds a real instruction
//   id_rs, id_rt          ID source registers
//   id_uses_rs/_rt        instruction actually reads rs / rt
//   id_wreg               destination register from the ID write-register mux
//   id_regwrite           instruction writes the register file
//   id_memread            instruction is a load
//   flush                 kill the ID instruction
//   stall                 hold PC and IF/ID (combinational)
//   fwd_a, fwd_b          EX operand selects, registered: 00 rf, 10 EX/MEM, 01 MEM/WB
//   byp_rs, byp_rt        WB writes id_rs / id_rt this cycle (combinational)
module wreg_track_unit #(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned ZERO_PROTECT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_wreg,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             byp_rs,
  output logic             byp_rt
);

  // Slot state. Only the EX slot needs the load flag: a load that has moved
  // on to MEM is forwarded normally, so MEM and WB never stall.
  logic             ex_v_q, ex_rw_q, ex_mr_q;
  logic [REG_W-1:0] ex_wreg_q;
  logic             mem_v_q, mem_rw_q;
  logic [REG_W-1:0] mem_wreg_q;
  logic             wb_v_q, wb_rw_q;
  logic [REG_W-1:0] wb_wreg_q;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;

  function automatic logic writes(input logic v, input logic rw,
                                  input logic [REG_W-1:0] wreg,
                                  input logic [REG_W-1:0] r);
    return v & rw & (wreg == r) & ((r != '0) | (ZERO_PROTECT == 0));
  endfunction

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
  logic accept;

  assign ex_hit_rs  = writes(ex_v_q, ex_rw_q, ex_wreg_q, id_rs);
  assign ex_hit_rt  = writes(ex_v_q, ex_rw_q, ex_wreg_q, id_rt);
  assign mem_hit_rs = writes(mem_v_q, mem_rw_q, mem_wreg_q, id_rs);
  assign mem_hit_rt = writes(mem_v_q, mem_rw_q, mem_wreg_q, id_rt);
  assign wb_hit_rs  = writes(wb_v_q, wb_rw_q, wb_wreg_q, id_rs);
  assign wb_hit_rt  = writes(wb_v_q, wb_rw_q, wb_wreg_q, id_rt);

  // Load in EX feeding an ID source: its data is not ready until MEM/WB.
  // Flush overrides, since the dependent instruction is being killed anyway.
  assign stall = id_valid & ~flush & ex_mr_q &
                 ((ex_hit_rs & id_uses_rs) | (ex_hit_rt & id_uses_rt));

  assign accept = id_valid & ~flush & ~stall;

  assign byp_rs = wb_hit_rs & id_uses_rs;
  assign byp_rt = wb_hit_rt & id_uses_rt;

  // Selects are computed against the slots as they are now; after the edge
  // the current EX producer sits in EX/MEM and the MEM producer in MEM/WB.
  // EX is checked first so the nearest producer wins.
  always_comb begin
    fwd_a_d = 2'b00;
    if (accept && id_uses_rs) begin
      if (ex_hit_rs)       fwd_a_d = 2'b10;
      else if (mem_hit_rs) fwd_a_d = 2'b01;
    end
  end

  always_comb begin
    fwd_b_d = 2'b00;
    if (accept && id_uses_rt) begin
      if (ex_hit_rt)       fwd_b_d = 2'b10;
      else if (mem_hit_rt) fwd_b_d = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q     <= 1'b0;
      ex_rw_q    <= 1'b0;
      ex_mr_q    <= 1'b0;
      ex_wreg_q  <= '0;
      mem_v_q    <= 1'b0;
      mem_rw_q   <= 1'b0;
      mem_wreg_q <= '0;
      wb_v_q     <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_wreg_q  <= '0;
      fwd_a_q    <= 2'b00;
      fwd_b_q    <= 2'b00;
    end else begin
      wb_v_q     <= mem_v_q;
      wb_rw_q    <= mem_rw_q;
      wb_wreg_q  <= mem_wreg_q;
      mem_v_q    <= ex_v_q;
      mem_rw_q   <= ex_rw_q;
      mem_wreg_q <= ex_wreg_q;
      // A rejected ID instruction leaves a bubble behind it.
      ex_v_q     <= accept;
      ex_rw_q    <= accept & id_regwrite;
      ex_mr_q    <= accept & id_memread;
      ex_wreg_q  <= id_wreg;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

endmodule

// File: tb/tb_wreg_track_unit.sv
module tb_wreg_track_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_wreg;
  logic       id_uses_rs, id_uses_rt, id_regwrite, id_memread, flush;
  logic       stall, byp_rs, byp_rt;
  logic [1:0] fwd_a, fwd_b;

  wreg_track_unit #(.REG_W(5), .ZERO_PROTECT(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_wreg     (id_wreg),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .stall       (stall),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .byp_rs      (byp_rs),
    .byp_rt      (byp_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       brs;
    logic       brt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_n    = 0;

  // Drive one cycle of ID inputs (just after the rising edge) and queue the
  // outputs expected in that same cycle: stall/byp from these inputs, fwd
  // from what the previous edge registered.
  task automatic step(input logic rn, input logic v, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urs, input logic urt,
                      input logic [4:0] wreg, input logic rw, input logic mr,
                      input logic fl, input logic es, input logic [1:0] efa,
                      input logic [1:0] efb, input logic ebrs, input logic ebrt);
    exp_t e;
    rst_n = rn; id_valid = v; id_rs = rs; id_rt = rt;
    id_uses_rs = urs; id_uses_rt = urt; id_wreg = wreg;
    id_regwrite = rw; id_memread = mr; flush = fl;
    e.id = vec_n; e.stall = es; e.fa = efa; e.fb = efb; e.brs = ebrs; e.brt = ebrt;
    exp_q.push_back(e);
    vec_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input int id, input logic got, input logic want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL vec%0d %s: got %b want %b", id, nm, got, want);
  endtask

  task automatic chk2(input string nm, input int id, input logic [1:0] got,
                      input logic [1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL vec%0d %s: got %b want %b", id, nm, got, want);
  endtask

  // Monitor: every mid-cycle sample point with a pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk1("stall",  cur.id, stall,  cur.stall);
      chk2("fwd_a",  cur.id, fwd_a,  cur.fa);
      chk2("fwd_b",  cur.id, fwd_b,  cur.fb);
      chk1("byp_rs", cur.id, byp_rs, cur.brs);
      chk1("byp_rt", cur.id, byp_rt, cur.brt);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_wreg = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_regwrite = 1'b0;
    id_memread = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    //    rn v  rs  rt urs urt wr rw mr fl   st fa     fb     brs brt
    // reset held with busy-looking inputs
    step(0, 1,  3,  3, 1, 1,  3, 1, 1, 0,   0, 2'b00, 2'b00, 0, 0);
    step(0, 1,  3,  3, 1, 1,  3, 1, 1, 0,   0, 2'b00, 2'b00, 0, 0);
    // R-type chain: add $3 ; sub reads $3 -> fwd_a=10 in sub's EX
    step(1, 1,  1,  2, 1, 1,  3, 1, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    step(1, 1,  3,  4, 1, 1,  6, 1, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    // add $3 ; or $8 (independent) ; and reads $3 -> fwd_a=01
    step(1, 1,  1,  2, 1, 1,  3, 1, 0, 0,   0, 2'b10, 2'b00, 0, 0);
    step(1, 1, 10, 11, 1, 1,  8, 1, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    step(1, 1,  3, 13, 1, 1, 12, 1, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    // load-use: lw $5 ; add reads rt=$5 -> one stall, then fwd_b=01
    step(1, 1, 20,  5, 1, 0,  5, 1, 1, 0,   0, 2'b01, 2'b00, 0, 0);
    step(1, 1, 15,  5, 1, 1, 14, 1, 0, 0,   1, 2'b00, 2'b00, 0, 0);
    step(1, 1, 15,  5, 1, 1, 14, 1, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    // priority: two writers of $7 then reader -> fwd_a=10; unused rt=$5 in WB -> no byp
    step(1, 1, 16,  5, 1, 0,  7, 1, 0, 0,   0, 2'b00, 2'b01, 0, 0);
    step(1, 1, 17, 18, 1, 1,  7, 1, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    step(1, 1,  7, 19, 1, 1, 20, 1, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    // $0: load to $0 then reader of $0 -> no stall, fwd 00
    step(1, 1,  1,  2, 1, 1,  0, 1, 1, 0,   0, 2'b10, 2'b00, 0, 0);
    step(1, 1,  0,  0, 1, 1, 21, 1, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    // flush: lw $2 ; flushed reader of $2 -> no stall; then EX empty
    step(1, 1, 22,  0, 1, 0,  2, 1, 1, 0,   0, 2'b00, 2'b00, 0, 0);
    step(1, 1,  2,  2, 1, 1, 23, 1, 0, 1,   0, 2'b00, 2'b00, 0, 0);
    step(1, 1,  2, 25, 1, 1, 26, 1, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    // WB bypass: writer $9 ; two fillers ; reader of $9 as writer hits WB
    step(1, 1, 27, 28, 1, 1,  9, 1, 0, 0,   0, 2'b01, 2'b00, 0, 0);
    step(1, 1, 29, 30, 1, 1, 31, 1, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    step(1, 1,  1,  9, 1, 0,  4, 0, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    step(1, 1,  9,  9, 1, 1, 10, 1, 0, 0,   0, 2'b00, 2'b00, 1, 1);
    step(1, 0, 10, 10, 1, 1,  0, 0, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    // set up fwd_a=01 and a load in EX, then assert reset mid-cycle
    step(1, 1, 10,  0, 1, 0, 11, 1, 1, 0,   0, 2'b00, 2'b00, 0, 0);
    step(0, 1, 11, 10, 1, 1, 12, 1, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    step(1, 1, 11, 10, 1, 1, 12, 1, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    step(1, 0,  0,  0, 0, 0,  0, 0, 0, 0,   0, 2'b00, 2'b00, 0, 0);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
